// File: rtl/bf16_result_buffer.sv
// Result buffer for a bfloat16 adder: captures each new result on a ready rising
// edge, expands it to fp32, classifies it and queues it in a FIFO.
// Optional macro BF16_NAN_CANON_EN stores every NaN as the canonical fp32 quiet NaN.
module bf16_result_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic [15:0]              sum,
    input  logic                     ready,
    output logic [31:0]              out_data,
    output logic [2:0]               out_class,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    typedef enum logic {
        WAIT_IDLE = 1'b0,
        ARMED     = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ready_q;
    logic              ready_rise;
    logic              push_c;
    logic              pop;
    logic              accept;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic [31:0]       mem_data  [DEPTH];
    logic [2:0]        mem_class [DEPTH];
    logic [31:0]       new_data;
    logic [2:0]        new_class;

    function automatic logic [2:0] classify(input logic [7:0] e, input logic [6:0] m);
        if (e == 8'h00)
            return (m == 7'h00) ? CLS_ZERO : CLS_SUB;
        else if (e != 8'hFF)
            return CLS_NORM;
        else if (m == 7'h00)
            return CLS_INF;
        else if (m[6])
            return CLS_QNAN;
        else
            return CLS_SNAN;
    endfunction

    assign ready_rise = ready & ~ready_q;

    // State register and ready history
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state   <= WAIT_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready;
        end
    end

    // The first rising edge after reset is the adder's idle indication, not a result
    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        case (state)
            WAIT_IDLE: if (ready_rise) state_nxt = ARMED;
            ARMED:     push_c = ready_rise;
            default:   state_nxt = WAIT_IDLE;
        endcase
    end

    // Expansion and classification of the incoming result
    always_comb begin
        new_data  = {sum, 16'h0000};
        new_class = classify(sum[14:7], sum[6:0]);
`ifdef BF16_NAN_CANON_EN
        if (sum[14:7] == 8'hFF && sum[6:0] != 7'h00) begin
            new_data  = 32'h7FC0_0000;
            new_class = CLS_QNAN;
        end
`endif
    end

    assign out_valid = (cnt != CW'(0));
    assign full      = (cnt == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign accept    = push_c & (~full | pop);
    assign count     = cnt;
    assign overflow  = ovf;

    // Head entry is forced to zero while empty so reset leaves a defined output
    assign out_data  = out_valid ? mem_data[rd_ptr]  : 32'h0000_0000;
    assign out_class = out_valid ? mem_class[rd_ptr] : 3'd0;

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_data[wr_ptr]  <= new_data;
            mem_class[wr_ptr] <= new_class;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (!nreset) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            cnt    <= CW'(0);
            ovf    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push_c && full && !pop) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf16_result_buffer.sv
// Directed scoreboard bench for bf16_result_buffer (DEPTH=4).
module tb_bf16_result_buffer;

    logic        clock;
    logic        nreset;
    logic [15:0] sum;
    logic        ready;
    logic [31:0] out_data;
    logic [2:0]  out_class;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [34:0] sb[$];

    bf16_result_buffer #(.DEPTH(4)) dut (
        .clock(clock), .nreset(nreset), .sum(sum), .ready(ready),
        .out_data(out_data), .out_class(out_class), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .full(full), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference expansion: {class, fp32}
    function automatic logic [34:0] model(input logic [15:0] s);
        logic [7:0] e;
        logic [6:0] m;
        logic [2:0] c;
        logic [31:0] d;
        e = s[14:7];
        m = s[6:0];
        d = {s, 16'h0000};
        if (e == 8'h00)      c = (m == 7'h00) ? 3'd0 : 3'd1;
        else if (e != 8'hFF) c = 3'd2;
        else if (m == 7'h00) c = 3'd3;
        else if (m[6])       c = 3'd4;
        else                 c = 3'd5;
`ifdef BF16_NAN_CANON_EN
        if (e == 8'hFF && m != 7'h00) begin
            d = 32'h7FC0_0000;
            c = 3'd4;
        end
`endif
        return {c, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One ready pulse carrying s; the scoreboard learns of it only if a push is expected
    task automatic pulse(input logic [15:0] s, input bit exp_push);
        sum   = s;
        ready = 1'b1;
        if (exp_push) sb.push_back(model(s));
        step();
        ready = 1'b0;
        step();
    endtask

    // Compare head against scoreboard front, then pop it
    task automatic pop_check(input string tag);
        logic [34:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"},  out_data, e[31:0]);
            chk({tag, "_class"}, 32'(out_class), 32'(e[34:32]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
        sb.delete();
    endtask

    initial begin
        nreset    = 1'b0;
        sum       = 16'h0000;
        ready     = 1'b0;
        out_ready = 1'b0;
        do_reset();

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_class", 32'(out_class), 32'd0);

        // Idle edge discarded, then first real result
        pulse(16'h3F80, 1'b0);
        chk("idle_count", 32'(count), 32'd0);
        pulse(16'h3F80, 1'b1);
        chk("first_count", 32'(count), 32'd1);
        chk("first_data",  out_data, 32'h3F80_0000);
        chk("first_class", 32'(out_class), 32'd2);
        pop_check("first");
        chk("empty_after_pop", 32'(out_valid), 32'd0);

        // Ordering
        pulse(16'h4000, 1'b1);
        pulse(16'h4234, 1'b1);
        chk("ord_head", out_data, 32'h4000_0000);
        pop_check("ord0");
        chk("ord_next", out_data, 32'h4234_0000);
        pop_check("ord1");

        // NaN / infinity
        pulse(16'h7F81, 1'b1);
        pulse(16'hFF80, 1'b1);
`ifdef BF16_NAN_CANON_EN
        chk("snan_data",  out_data, 32'h7FC0_0000);
        chk("snan_class", 32'(out_class), 32'd4);
`else
        chk("snan_data",  out_data, 32'h7F81_0000);
        chk("snan_class", 32'(out_class), 32'd5);
`endif
        pop_check("snan");
        chk("inf_data",  out_data, 32'hFF80_0000);
        chk("inf_class", 32'(out_class), 32'd3);
        pop_check("inf");

        // Remaining classes including signed qNaN
        pulse(16'h8000, 1'b1);
        pulse(16'h8001, 1'b1);
        pulse(16'hFFC1, 1'b1);
        chk("cls_zero", 32'(out_class), 32'd0);
        pop_check("zero");
        chk("cls_sub",  32'(out_class), 32'd1);
        pop_check("sub");
        pop_check("qnan");

        // Ready held high produces a single edge
        sum   = 16'h4100;
        ready = 1'b1;
        sb.push_back(model(16'h4100));
        step(); step(); step();
        ready = 1'b0;
        step();
        chk("held_count", 32'(count), 32'd1);
        pop_check("held");

        // Fill, overflow and drain
        for (int i = 1; i <= 4; i++) pulse(16'(i), 1'b1);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf",   32'(overflow), 32'd0);
        pulse(16'h0005, 1'b0);
        chk("drop_count", 32'(count), 32'd4);
        chk("drop_ovf",   32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", out_data, {16'(i), 16'h0000});
            pop_check("drain");
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_ovf",   32'(overflow), 32'd1);

        // Full FIFO with coincident push and pop
        do_reset();
        chk("rst2_ovf", 32'(overflow), 32'd0);
        pulse(16'h3F80, 1'b0);
        for (int i = 0; i < 4; i++) pulse(16'(16'h0010 + i), 1'b1);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_head", out_data, 32'h0010_0000);
        void'(sb.pop_front());
        sb.push_back(model(16'h0014));
        sum       = 16'h0014;
        ready     = 1'b1;
        out_ready = 1'b1;
        step();
        ready     = 1'b0;
        out_ready = 1'b0;
        step();
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("pp_drain");
        chk("pp_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation
        pulse(16'h4000, 1'b1);
        pulse(16'h4040, 1'b1);
        chk("mid_count", 32'(count), 32'd2);
        do_reset();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        pulse(16'h4080, 1'b0);
        chk("mid_idle_count", 32'(count), 32'd0);
        pulse(16'h40A0, 1'b1);
        chk("mid_push_count", 32'(count), 32'd1);
        chk("mid_push_data", out_data, 32'h40A0_0000);
        pop_check("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bf16_result_buffer.md
BF16_RESULT_BUFFER -- requirements
Module: bf16_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 sum  input  16  bfloat16 result from upstream adder; valid while ready=1.
REQ-005 ready  input  1  adder ready level; a 0->1 transition marks a new result.
REQ-006 out_data  output  32  fp32 expansion of the buffered result.
REQ-007 out_class  output  3  class code: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts the head entry when out_valid=1.
REQ-010 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 full  output  1  count==DEPTH.
REQ-012 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-013 SHALL register ready into ready_q each cycle; edge = ready & ~ready_q.
REQ-014 FSM states WAIT_IDLE, ARMED; WAIT_IDLE->ARMED on first edge after reset, which is the adder's post-reset idle indication and SHALL be discarded.
REQ-015 In ARMED each edge SHALL push sum, its expansion and class; the entry is visible at out_valid on the following cycle (latency 1 from edge cycle).
REQ-016 Expansion SHALL be {sum,16'h0000}, except NaN handling per REQ-027/028.
REQ-017 Classification from sum: exp==0 & man==0 -> 0; exp==0 & man!=0 -> 1; exp 1..254 -> 2; exp==255 & man==0 -> 3; exp==255 & man[6]=1 -> 4; exp==255 & man[6]=0 & man!=0 -> 5; sign ignored.
REQ-018 Pop SHALL occur when out_valid & out_ready; next entry or out_valid=0 next cycle.
REQ-019 out_data/out_class SHALL reflect the head entry combinationally from storage; undefined-but-stable when out_valid=0.
REQ-020 Push and pop same cycle SHALL both occur; count unchanged, including when full.
REQ-021 Push when full without pop SHALL drop the result, leave FIFO unchanged, set overflow=1.
REQ-022 overflow SHALL clear only on reset.
REQ-023 Pointers SHALL wrap modulo DEPTH; FIFO order strict first-in-first-out.
REQ-024 Edge while in WAIT_IDLE SHALL never push; ready held high SHALL produce one edge only.

Reset
REQ-025 On nreset=0 at a clock edge: state=WAIT_IDLE, ready_q=0, pointers=0, count=0, out_valid=0, full=0, overflow=0; out_data/out_class=0.
REQ-026 Reset mid-operation SHALL discard all buffered entries; the next ready edge is again discarded per REQ-014.

Configuration
REQ-027 Macro BF16_NAN_CANON_EN defined: any NaN SHALL be stored as out_data=32'h7FC00000 with sign 0, out_class=4.
REQ-028 Macro undefined: NaN payload and sign preserved via REQ-016; class 4 or 5 per REQ-017.

Verification
REQ-029 Reset, ready 0->1 (idle), then sum=16'h3F80+ready edge -> idle edge discarded; one entry out_data=32'h3F800000, class 2, count=1.
REQ-030 Armed; sum=16'h4000 edge, then sum=16'h4234 edge, out_ready=1 -> out_data 32'h40000000 then 32'h42340000 in order, class 2 each.
REQ-031 sum=16'h7F81 edge -> macro defined: 32'h7FC00000 class 4; undefined: 32'h7F810000 class 5; sum=16'hFF80 -> 32'hFF800000 class 3.
REQ-032 DEPTH=4, out_ready=0, five edges with sums 1..5 -> full=1 after 4th, 5th dropped, overflow=1; drain yields sums 1..4, overflow stays 1.
REQ-033 Full FIFO, edge coincident with pop -> count stays 4, new entry at tail, overflow unchanged 0.
REQ-034 Two entries buffered, nreset=0 one cycle -> count=0, out_valid=0; next edge discarded, following edge pushes.
